// File: rtl/hit_judge.sv
// Note judge: turns the script position stream into notes, carries them down a lane,
// and grades key presses as PERFECT / GOOD / MISS. Optional HIT_JUDGE_STRAY_PENALTY_EN.
module hit_judge #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned WINDOW      = 4,
   parameter int unsigned PERFECT_PTS = 2,
   parameter int unsigned GOOD_PTS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 beat,
   input  logic [3:0]           pos_in,
   input  logic [8:0]           key,
   output logic [4*DEPTH-1:0]   lane,
   output logic [1:0]           judge,
   output logic                 judge_valid,
   output logic [15:0]          score,
   output logic [7:0]           combo,
   output logic [7:0]           max_combo
);

   localparam int unsigned WIN_W = $clog2(WINDOW + 1);

   localparam logic [1:0] J_NONE    = 2'd0;
   localparam logic [1:0] J_PERFECT = 2'd1;
   localparam logic [1:0] J_GOOD    = 2'd2;
   localparam logic [1:0] J_MISS    = 2'd3;

   typedef enum logic {IDLE, OPEN} state_t;

   state_t             state, state_nxt;
   logic [3:0]         target, target_nxt;
   logic [WIN_W-1:0]   win_cnt, win_nxt, win_inc;
   logic [3:0]         last_pos;
   logic [8:0]         key_q, rise, hot_tgt, hot_arr;
   logic [3:0]         new_code, arrive_code;
   logic               arrive;
   logic [1:0]         jres;
   logic               drop_pending;
`ifdef HIT_JUDGE_STRAY_PENALTY_EN
   logic               stray;
`endif
   logic [1:0]         judge_nxt;
   logic [15:0]        score_nxt;
   logic [16:0]        score_sum;
   logic [15:0]        pts;
   logic [7:0]         combo_base, combo_nxt, max_nxt;

   function automatic logic [8:0] code_hot(input logic [3:0] c);
      code_hot = (c == 4'd0) ? 9'd0 : 9'(9'd1 << (c - 4'd1));
   endfunction

   // Onset: a new note only when the code is a real position and differs from the last beat
   assign new_code    = (pos_in >= 4'd1 && pos_in <= 4'd9 && pos_in != last_pos) ? pos_in : 4'd0;
   assign arrive_code = lane[4*(DEPTH-2) +: 4];
   assign arrive      = beat && (arrive_code != 4'd0);
   assign rise        = key & ~key_q;
   assign hot_tgt     = code_hot(target);
   assign hot_arr     = code_hot(arrive_code);
   assign win_inc     = win_cnt + WIN_W'(1);

   // Next-state and judgement; an arrival preempts the pending note and any key edge grades the new one
   always_comb begin
      state_nxt    = state;
      target_nxt   = target;
      win_nxt      = win_cnt;
      jres         = J_NONE;
      drop_pending = 1'b0;
`ifdef HIT_JUDGE_STRAY_PENALTY_EN
      stray        = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (arrive) begin
               state_nxt  = OPEN;
               target_nxt = arrive_code;
               win_nxt    = '0;
               if (rise != 9'd0) begin
                  jres      = (rise == hot_arr) ? J_PERFECT : J_MISS;
                  state_nxt = IDLE;
               end
            end
`ifdef HIT_JUDGE_STRAY_PENALTY_EN
            else if (rise != 9'd0) begin
               stray = 1'b1;
            end
`endif
         end
         OPEN: begin
            if (arrive) begin
               drop_pending = 1'b1;
               target_nxt   = arrive_code;
               win_nxt      = '0;
               jres         = J_MISS;
               if (rise != 9'd0) begin
                  jres      = (rise == hot_arr) ? J_PERFECT : J_MISS;
                  state_nxt = IDLE;
               end
            end else if (rise != 9'd0) begin
               if (rise == hot_tgt) begin
                  jres = (win_cnt == '0) ? J_PERFECT : J_GOOD;
               end else begin
                  jres = J_MISS;
               end
               state_nxt = IDLE;
            end else if (beat) begin
               if (win_inc == WIN_W'(WINDOW)) begin
                  jres      = J_MISS;
                  state_nxt = IDLE;
               end else begin
                  win_nxt = win_inc;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Score / combo bookkeeping; a preempted note clears the combo before the new result applies
   always_comb begin
      pts        = 16'd0;
      score_nxt  = score;
      combo_base = drop_pending ? 8'd0 : combo;
      combo_nxt  = combo;
      judge_nxt  = judge;
      if (jres == J_PERFECT) pts = 16'(PERFECT_PTS);
      if (jres == J_GOOD)    pts = 16'(GOOD_PTS);
      score_sum = {1'b0, score} + 17'(pts);
      if (jres == J_PERFECT || jres == J_GOOD) begin
         score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
         combo_nxt = (combo_base == 8'hFF) ? 8'hFF : combo_base + 8'd1;
      end else if (jres == J_MISS) begin
         combo_nxt = 8'd0;
      end
`ifdef HIT_JUDGE_STRAY_PENALTY_EN
      else if (stray) begin
         combo_nxt = 8'd0;
      end
`endif
      if (jres != J_NONE) judge_nxt = jres;
      max_nxt = (combo_nxt > max_combo) ? combo_nxt : max_combo;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane        <= '0;
         last_pos    <= 4'd0;
         key_q       <= 9'd0;
         state       <= IDLE;
         target      <= 4'd0;
         win_cnt     <= '0;
         judge       <= J_NONE;
         judge_valid <= 1'b0;
         score       <= 16'd0;
         combo       <= 8'd0;
         max_combo   <= 8'd0;
      end else begin
         key_q <= key;
         if (beat) begin
            last_pos <= pos_in;
            lane     <= {lane[4*DEPTH-5:0], new_code};
         end
         state       <= state_nxt;
         target      <= target_nxt;
         win_cnt     <= win_nxt;
         judge       <= judge_nxt;
         judge_valid <= (jres != J_NONE);
         score       <= score_nxt;
         combo       <= combo_nxt;
         max_combo   <= max_nxt;
      end
   end

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: expected judgements are queued as stimulus is driven
// and popped whenever judge_valid is seen.
module tb_hit_judge;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned WINDOW = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                beat;
   logic [3:0]          pos_in;
   logic [8:0]          key;
   logic [4*DEPTH-1:0]  lane;
   logic [1:0]          judge;
   logic                judge_valid;
   logic [15:0]         score;
   logic [7:0]          combo;
   logic [7:0]          max_combo;

   hit_judge #(.DEPTH(DEPTH), .WINDOW(WINDOW), .PERFECT_PTS(2), .GOOD_PTS(1)) dut (
      .clk(clk), .rst(rst), .beat(beat), .pos_in(pos_in), .key(key),
      .lane(lane), .judge(judge), .judge_valid(judge_valid),
      .score(score), .combo(combo), .max_combo(max_combo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  j;
      logic [15:0] s;
      logic [7:0]  c;
      logic [7:0]  m;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          m_score  = 0;
   int          m_combo  = 0;
   int          m_max    = 0;
   logic        prev_jv  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference bookkeeping for one judgement, queued for the monitor
   task automatic exp_push(input logic [1:0] j);
      exp_t e;
      if (j == 2'd1) begin m_score += 2; m_combo = (m_combo == 255) ? 255 : m_combo + 1; end
      if (j == 2'd2) begin m_score += 1; m_combo = (m_combo == 255) ? 255 : m_combo + 1; end
      if (j == 2'd3) m_combo = 0;
      if (m_score > 16'hFFFF) m_score = 16'hFFFF;
      if (m_combo > m_max) m_max = m_combo;
      e.j = j; e.s = 16'(m_score); e.c = 8'(m_combo); e.m = 8'(m_max);
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && judge_valid === 1'b1) begin
         check("jv_pulse", 32'(prev_jv), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_judge", 32'(judge_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("judge", 32'(judge), 32'(e.j));
            check("score", 32'(score), 32'(e.s));
            check("combo", 32'(combo), 32'(e.c));
            check("max_combo", 32'(max_combo), 32'(e.m));
         end
      end
      prev_jv = judge_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [3:0] p, input int k = -1);
      beat = 1'b1;
      pos_in = p;
      if (k >= 0) key[k] = 1'b1;
      tick();
      beat = 1'b0;
      key = 9'd0;
      tick();
   endtask

   task automatic press(input int k);
      key[k] = 1'b1;
      tick();
      key = 9'd0;
      tick();
   endtask

   task automatic send_note(input logic [3:0] p);
      step(p);
      repeat (DEPTH - 1) step(4'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_lane"}, lane, 32'd0);
      check({tag, "_judge"}, 32'(judge), 32'd0);
      check({tag, "_jv"}, 32'(judge_valid), 32'd0);
      check({tag, "_score"}, 32'(score), 32'd0);
      check({tag, "_combo"}, 32'(combo), 32'd0);
      check({tag, "_max"}, 32'(max_combo), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; beat = 1'b0; pos_in = 4'd0; key = 9'd0;
      repeat (2) tick();
      check_all_zero("reset");
      rst = 1'b1;
      tick();

      // Held run of code 1: one note, walking down the lane
      for (int b = 1; b <= 8; b++) begin
         step(4'd1);
         check($sformatf("lane_b%0d", b), lane, 32'(32'h1 << (4 * (b - 1))));
      end
      exp_push(2'd1);
      press(0);

      // GOOD two beats into the window
      send_note(4'd2);
      repeat (2) step(4'd0);
      exp_push(2'd2);
      press(1);

      // Expiry on the WINDOW-th beat
      send_note(4'd3);
      repeat (WINDOW - 1) step(4'd0);
      exp_push(2'd3);
      step(4'd0);

      // Wrong key, then a late correct key that must be ignored
      send_note(4'd2);
      exp_push(2'd3);
      press(4);
      press(1);
      check("combo_after_wrong", 32'(combo), 32'd0);

      // Back-to-back notes: first preempted, second expires
      step(4'd1);
      step(4'd2);
      repeat (DEPTH - 2) step(4'd0);
      exp_push(2'd3);
      step(4'd0);
      repeat (WINDOW - 1) step(4'd0);
      exp_push(2'd3);
      step(4'd0);

      // Three consecutive hits to build combo 3
      step(4'd1);
      step(4'd2);
      step(4'd3);
      repeat (DEPTH - 3) step(4'd0);
      exp_push(2'd1);
      press(0);
      step(4'd0);
      exp_push(2'd1);
      press(1);
      step(4'd0);
      exp_push(2'd1);
      press(2);
      check("combo_3", 32'(combo), 32'd3);

      // Stray key while idle
      press(5);
`ifdef HIT_JUDGE_STRAY_PENALTY_EN
      m_combo = 0;
`endif
      check("combo_stray", 32'(combo), 32'(m_combo));
      check("max_stray", 32'(max_combo), 32'd3);

      // Key pressed on the same beat that would expire the window wins
      send_note(4'd5);
      repeat (WINDOW - 1) step(4'd0);
      exp_push(2'd2);
      step(4'd0, 4);

      // Reset mid-window drops the pending note
      send_note(4'd6);
      step(4'd0);
      rst = 1'b0;
      #2;
      check_all_zero("midrst");
      tick();
      rst = 1'b1;
      m_score = 0; m_combo = 0; m_max = 0;
      repeat (WINDOW + 1) step(4'd0);
      check("judge_after_rst", 32'(judge), 32'd0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hit_judge.md
# hit_judge

Note-judging stage that sits directly downstream of the script note generator in the rhythm game. It samples the 4-bit position stream (0 = none, 1..9 = Q W E A S D Z X C) once per beat, reduces each held run to a single note, and carries it down a DEPTH-beat lane to the hit line. It then grades the player's key press against that note as PERFECT, GOOD or MISS, and keeps score and combo for the display and scoring logic.

## Interface
- DEPTH, 8: number of beats a note travels from spawn to the hit line (≥2).
- WINDOW, 4: number of beats the judge window stays open after arrival (≥1).
- PERFECT_PTS, 2: points awarded for a PERFECT.
- GOOD_PTS, 1: points awarded for a GOOD.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- beat  in  1  one-clk pulse per script step, synchronous to clk.
- pos_in  in  4  position code from the script; sampled only when beat=1.
- key  in  9  debounced key levels; bit i-1 corresponds to code i.
- lane  out  4*DEPTH  flattened note lane; slot k is bits [4k+3:4k]; slot 0 is newest, slot DEPTH-1 is the hit line.
- judge  out  2  0 = none, 1 = PERFECT, 2 = GOOD, 3 = MISS.
- judge_valid  out  1  one-clk pulse qualifying judge.
- score  out  16  accumulated score, saturating at 16'hFFFF.
- combo  out  8  current combo, saturating at 255.
- max_combo  out  8  highest combo since reset.

## Operation
- Onset detection happens on beat. If pos_in is in 1..9 and differs from last_pos, the block pushes pos_in into lane slot 0; otherwise it pushes 0. last_pos ← pos_in on every beat. Codes 10..15 are treated as 0.
- Lane shift happens on beat: slot k+1 ← slot k, and slot DEPTH-1 is discarded.
- Key edges: rise = key & ~key_q, with key_q registered every clk. A match means rise equals the one-hot of target.
- FSM states are IDLE and OPEN. Registers are target[3:0] and win_cnt (width ceil(log2(WINDOW+1))).
  - IDLE → OPEN: on a beat that shifts a nonzero code into slot DEPTH-1. Sets target ← that code and win_cnt ← 0.
  - OPEN, rise≠0 and match, win_cnt==0: PERFECT, then → IDLE.
  - OPEN, rise≠0 and match, win_cnt>0: GOOD, then → IDLE.
  - OPEN, rise≠0 and no match (wrong key or multiple keys): MISS, then → IDLE.
  - OPEN, beat: win_cnt increments. If the incremented value equals WINDOW, the result is MISS and the FSM goes → IDLE.
  - OPEN, beat that also brings a new nonzero note to the hit line: the pending note is judged MISS and the FSM stays OPEN with the new target and win_cnt=0. A key edge in the same cycle is judged against the new note.
  - IDLE, rise≠0: ignored (see Configuration).
- Bookkeeping on judgement:
  - PERFECT/GOOD: score += pts, saturating; combo += 1, saturating at 255; max_combo ← max(max_combo, new combo).
  - MISS: combo ← 0; score unchanged.

## Timing
- Reset values: lane = 0, last_pos = 0, key_q = 0, state = IDLE, target = 0, win_cnt = 0, judge = 0, judge_valid = 0, score = 0, combo = 0, max_combo = 0.
- A note sampled on beat n is in slot 0 after that clk edge and reaches slot DEPTH-1 after beat n+DEPTH-1.
- The judge window is counted from that arrival beat.
- judge, judge_valid, score, combo and max_combo are registered. They update on the clk edge after the triggering key edge or beat, so latency is 1 clk.
- judge holds its value until the next judgement. judge_valid is high for exactly one clk.
- A key held across beats produces no further edges.
- A key pressed in the same clk as a beat takes priority over the expiry check of that beat.
- Reset asserted mid-window clears everything immediately. The pending note produces no judgement.

## Configuration
- HIT_JUDGE_STRAY_PENALTY_EN
  - Defined: any rise≠0 while IDLE resets combo to 0. score is unchanged and no judge_valid is produced.
  - Undefined: key edges in IDLE are ignored entirely.

## Test plan
- Reset → all outputs 0. Feed pos_in = 1 for 8 beats → lane slot 0 shows 1 for exactly one beat, and the note reaches slot 7 after 7 further beats.
- Press key[0] in the clk after the arrival beat → judge = 1, judge_valid for 1 clk, score = 2, combo = 1, max_combo = 1.
- Press the matching key after 2 beats into the window → GOOD, score += 1. With no press for 4 beats → MISS on the 4th beat and combo = 0.
- Window open with target 2 (W), press key[4] (S) → MISS on the next clk. A later key[1] press is ignored.
- Two notes 1 beat apart (DEPTH unchanged, WINDOW = 4), no keys pressed → the first note is MISSed on the beat the second arrives, and the second is MISSed 4 beats later.
- With HIT_JUDGE_STRAY_PENALTY_EN defined: combo = 3, press any key while IDLE → combo = 0, no judge_valid. Without the macro, combo stays 3.
